// File: rtl/hc595_shift_driver.sv
// Serial driver for a cascaded 74HC595-style chain: shifts a word out MSB first
// on a divided SRCLK, then pulses RCLK so every chip output updates at once.
module hc595_shift_driver #(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] Data,
   input  logic              Valid,
   output logic              Ready,
   output logic              SER,
   output logic              SRCLK,
   output logic              RCLK,
   output logic              OE_n
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SHIFT_LO = 2'd1;
   localparam logic [1:0] SHIFT_HI = 2'd2;
   localparam logic [1:0] LATCH    = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [CNT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              ready_q, ready_d;
   logic              ser_q, ser_d;
   logic              srclk_q, srclk_d;
   logic              rclk_q, rclk_d;
   logic              oe_n_q, oe_n_d;
   logic              div_last;

   assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      ready_d = ready_q;
      ser_d   = ser_q;
      srclk_d = srclk_q;
      rclk_d  = rclk_q;
      oe_n_d  = oe_n_q;
      case (state_q)
         IDLE: begin
            div_d = '0;
            if (Valid) begin
               state_d = SHIFT_LO;
               ready_d = 1'b0;
               shreg_d = Data;
               ser_d   = Data[DATA_W-1];
               bit_d   = CNT_W'(DATA_W - 1);
            end
         end
         SHIFT_LO: begin
            if (div_last) begin
               div_d   = '0;
               srclk_d = 1'b1;
               state_d = SHIFT_HI;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         SHIFT_HI: begin
            if (div_last) begin
               div_d   = '0;
               srclk_d = 1'b0;
               // SER only moves on the SRCLK fall, centring each bit on the rise
               if (bit_q == '0) begin
                  rclk_d  = 1'b1;
                  state_d = LATCH;
               end else begin
                  bit_d   = bit_q - 1'b1;
                  ser_d   = shreg_q[bit_q - 1'b1];
                  state_d = SHIFT_LO;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         LATCH: begin
            if (div_last) begin
               div_d   = '0;
               rclk_d  = 1'b0;
               oe_n_d  = 1'b0;
               ready_d = 1'b1;
               ser_d   = 1'b0;
               state_d = IDLE;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         ready_q <= 1'b1;
         ser_q   <= 1'b0;
         srclk_q <= 1'b0;
         rclk_q  <= 1'b0;
         oe_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         ready_q <= ready_d;
         ser_q   <= ser_d;
         srclk_q <= srclk_d;
         rclk_q  <= rclk_d;
         oe_n_q  <= oe_n_d;
      end
   end

   assign Ready = ready_q;
   assign SER   = ser_q;
   assign SRCLK = srclk_q;
   assign RCLK  = rclk_q;
   assign OE_n  = oe_n_q;

endmodule

// File: doc/hc595_shift_driver.md
Name: hc595_shift_driver

Overview:
- Parallel-to-serial transmitter that drives an external 74HC595-style shift/storage register chain (SER, SRCLK, RCLK, OE_n).
- Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out MSB first on a generated shift clock.
- Pulses the storage clock so the remote 8D storage register updates all outputs at once.
- Sits between display/LED control logic and the board's serial-latch chips.

Parameters:
- DATA_W, 16: bits per transaction (>=1; 16 = two cascaded 8-bit chips).
- CLK_DIV, 4: CLK cycles per half-period of SRCLK and per RCLK high pulse (>=1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- Data  in  DATA_W  word to transmit; sampled only on handshake.
- Valid  in  1  Data valid.
- Ready  out  1  block idle and able to accept a word.
- SER  out  1  serial data to chip.
- SRCLK  out  1  shift clock to chip; the chip samples on SRCLK rising.
- RCLK  out  1  storage-register clock to chip; rising edge transfers shifted data to outputs.
- OE_n  out  1  active-low output enable to chip.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST) and has priority over all other inputs.
- Reset values: state=IDLE, Ready=1, SER=0, SRCLK=0, RCLK=0, OE_n=1, bit counter=0, divider=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Handshake:
  - A transfer is accepted on the rising edge where Valid=1 and Ready=1 (edge T).
  - Data is copied into an internal shift register. Later changes on Data have no effect.
  - Valid while Ready=0 is ignored; the block never queues a word.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
  - IDLE:
    - Ready=1, SER=0, SRCLK=0, RCLK=0.
    - On handshake, go to SHIFT_LO, Ready<=0, SER<=Data[DATA_W-1].
  - SHIFT_LO:
    - SRCLK=0, SER holds the current bit.
    - After CLK_DIV cycles, go to SHIFT_HI and set SRCLK<=1.
  - SHIFT_HI:
    - SRCLK=1, SER stable for the whole high phase.
    - After CLK_DIV cycles:
      - If bits remain: SRCLK<=0, SER<=next lower bit, go to SHIFT_LO.
      - After bit 0: SRCLK<=0, RCLK<=1, go to LATCH.
  - LATCH:
    - RCLK=1 for CLK_DIV cycles, then RCLK<=0, OE_n<=0, Ready<=1, SER<=0, go to IDLE.
- Timing, counted from handshake edge T:
  - SHIFT_LO starts at T+1.
  - Each bit occupies 2*CLK_DIV cycles.
  - LATCH occupies CLK_DIV cycles.
  - Ready returns to 1 at T+1+(2*DATA_W+1)*CLK_DIV. For the defaults that is T+133.
  - Exactly DATA_W SRCLK rising edges and one RCLK rising edge per transfer.
- Back-to-back: Valid held high is accepted on the first cycle Ready=1, so at least one IDLE cycle separates transfers.
- OE_n:
  - Stays 1 from reset until the first LATCH completes, so the chip outputs stay disabled until they hold defined data.
  - Then stays 0 until the next reset.
- SER/SRCLK relation: SER only changes in the same cycle SRCLK goes low (or while idle), giving CLK_DIV cycles of setup and hold around each SRCLK rise.
- Reset mid-transfer:
  - Aborts immediately: SRCLK=0 and RCLK=0 after the reset edge, with no RCLK pulse.
  - OE_n returns to 1 and the partial data is never latched.
- CLK_DIV=1: SRCLK runs at CLK/2. All rules above still hold.

Test Plan:
- Reset: hold RST 3 cycles with Valid=1 -> Ready=1, SER=SRCLK=RCLK=0, OE_n=1, no handshake taken; release RST -> word accepted on the next edge.
- Single word, defaults, Data=16'hA5C3 -> exactly 16 SRCLK rises; SER sampled at each rise = 1010010111000011; one RCLK pulse 4 cycles wide after the last SRCLK fall; Ready=1 at T+133; OE_n falls with RCLK.
- Back-to-back: Valid held, Data=16'h0001 then 16'hFFFF -> second handshake at T+133; second SHIFT_LO at T+134; sampled streams match; 2 RCLK pulses in total.
- Busy ignore: during a transfer, pulse Valid with Data=16'h1234 -> no effect; stream and cycle count identical to the no-pulse run.
- Reset mid-transfer after 7 SRCLK rises -> SRCLK/RCLK low next cycle, no RCLK rise, OE_n=1, Ready=1; a new word then transfers normally.
- CLK_DIV=1, DATA_W=8, Data=8'h81 -> SRCLK period 2 cycles; 8 rises; SER samples 10000001; Ready=1 at T+18.
